// File: rtl/corr_pkg.sv
// Shared FSM state type and per-pixel similarity helper for the correlation engine.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } corrState_e;

  // Similarity of two pixels: maxPix - |a - b|. Both inputs fit in maxPix, so this never wraps.
  function automatic logic [31:0] pixScore(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] maxPix);
    logic [31:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return maxPix - diff;
  endfunction

endpackage

// File: rtl/corr_valid_pipe.sv
// Delay line that realigns the read-enable with returning SRAM data.
// With LAT = 0 it is a plain wire.
module corr_valid_pipe #(
  parameter int LAT = 2
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iClr,
  input  logic iValid,
  output logic oTap
);

  generate
    if (LAT == 0) begin : gNoDelay
      assign oTap = iValid;
    end else begin : gDelay
      logic [LAT-1:0] stage;

      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          stage <= '0;
        end else if (iClr) begin
          stage <= '0;
        end else begin
          stage <= LAT'({stage, iValid});
        end
      end

      assign oTap = stage[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/corr_score_engine.sv
// Template-correlation engine: scores a TPL_W x TPL_H template against a frame window.
// Optional best-position tracking is enabled by defining CORR_BEST_TRACK_EN.
module corr_score_engine
  import corr_pkg::*;
#(
  parameter  int PIX_W   = 10,
  parameter  int COORD_W = 13,
  parameter  int TPL_W   = 512,
  parameter  int TPL_H   = 384,
  parameter  int RD_LAT  = 2,
  localparam int ACC_W   = PIX_W + $clog2(TPL_W * TPL_H)
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic [COORD_W-1:0] iXstart,
  input  logic [COORD_W-1:0] iYstart,
  input  logic [PIX_W-1:0]   iPix_sram,
  input  logic [PIX_W-1:0]   iPix_tpl,
  output logic [COORD_W-1:0] oX_sram,
  output logic [COORD_W-1:0] oY_sram,
  output logic [COORD_W-1:0] oX_tpl,
  output logic [COORD_W-1:0] oY_tpl,
  output logic               oRd_en,
  output logic               oBusy,
  output logic               oDone,
  output logic [ACC_W-1:0]   oScore
`ifdef CORR_BEST_TRACK_EN
  ,
  input  logic               iClr_best,
  output logic [ACC_W-1:0]   oBest_score,
  output logic [COORD_W-1:0] oBest_X,
  output logic [COORD_W-1:0] oBest_Y
`endif
);

  localparam logic [PIX_W-1:0]   MAXPIX    = '1;
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(TPL_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(TPL_H - 1);
  localparam int                 DCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  corrState_e         state, stateNext;
  logic [COORD_W-1:0] xOrg, yOrg, xCnt, yCnt;
  logic [ACC_W-1:0]   acc, accNext, scoreReg;
  logic [DCNT_W-1:0]  drainCnt;
  logic [PIX_W-1:0]   sampleScore;
  logic               accept, lastAddr, drainLast, sampleValid;

  assign accept      = (state == IDLE) && iStart;
  assign lastAddr    = (xCnt == X_LAST) && (yCnt == Y_LAST);
  assign drainLast   = (drainCnt == DCNT_LAST);
  assign sampleScore = PIX_W'(pixScore(32'(iPix_sram), 32'(iPix_tpl), 32'(MAXPIX)));
  assign accNext     = sampleValid ? (acc + ACC_W'(sampleScore)) : acc;

  corr_valid_pipe #(.LAT(RD_LAT)) uValidPipe (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iClr  (accept),
    .iValid(oRd_en),
    .oTap  (sampleValid)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    // NOTE: default first so every path assigns stateNext and no latch is inferred.
    stateNext = state;
    case (state)
      IDLE:    if (iStart) stateNext = RUN;
      RUN:     if (lastAddr) stateNext = (RD_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drainLast) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xOrg     <= '0;
      yOrg     <= '0;
      xCnt     <= '0;
      yCnt     <= '0;
      acc      <= '0;
      drainCnt <= '0;
      scoreReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            xOrg <= iXstart;
            yOrg <= iYstart;
            xCnt <= '0;
            yCnt <= '0;
            acc  <= '0;
          end
        end
        RUN: begin
          acc      <= accNext;
          drainCnt <= '0;
          // Counters freeze on the final address so the address outputs hold it afterwards.
          if (!lastAddr) begin
            if (xCnt == X_LAST) begin
              xCnt <= '0;
              yCnt <= yCnt + 1'b1;
            end else begin
              xCnt <= xCnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          acc      <= accNext;
          drainCnt <= drainCnt + 1'b1;
        end
        default: ;
      endcase
      // Capture including the final sample so oScore is valid alongside oDone.
      if ((stateNext == DONE) && (state != DONE)) scoreReg <= accNext;
    end
  end

  assign oX_sram = xOrg + xCnt;
  assign oY_sram = yOrg + yCnt;
  assign oX_tpl  = xCnt;
  assign oY_tpl  = yCnt;
  assign oRd_en  = (state == RUN);
  assign oBusy   = (state == RUN) || (state == DRAIN);
  assign oDone   = (state == DONE);
  assign oScore  = scoreReg;

`ifdef CORR_BEST_TRACK_EN
  // Strict greater-than keeps the earlier position on ties.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oBest_score <= '0;
      oBest_X     <= '0;
      oBest_Y     <= '0;
    end else if (iClr_best) begin
      oBest_score <= '0;
      oBest_X     <= '0;
      oBest_Y     <= '0;
    end else if ((state == DONE) && (scoreReg > oBest_score)) begin
      oBest_score <= scoreReg;
      oBest_X     <= xOrg;
      oBest_Y     <= yOrg;
    end
  end
`endif

endmodule

// File: doc/corr_score_engine.md
Name: corr_score_engine

Overview:
- Parametrised template-correlation engine for pupil search: compares a TPL_W x TPL_H template against the frame-buffer window at (iXstart, iYstart) and accumulates the similarity score sum(MAXPIX - |frame - tpl|).
- Sits between the search controller, which issues one start per candidate position, and the SRAM frame / template readers.
- Adds a start/busy/done handshake, read-latency alignment, configurable window and pixel width, and full-width accumulation.

Parameters:
- PIX_W, 10, pixel width in bits; MAXPIX = 2^PIX_W-1.
- COORD_W, 13, coordinate width.
- TPL_W, 512, template width in pixels (>=1).
- TPL_H, 384, template height in pixels (>=1).
- RD_LAT, 2, read latency in cycles from address out to data in (>=0).
- ACC_W (localparam), PIX_W+clog2(TPL_W*TPL_H), accumulator width; never overflows.

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  asynchronous active-low reset.
- iStart  in  1  start pulse; sampled only in IDLE.
- iXstart  in  COORD_W  window origin X; latched on accepted start.
- iYstart  in  COORD_W  window origin Y; latched on accepted start.
- iPix_sram  in  PIX_W  frame pixel, valid RD_LAT cycles after its address.
- iPix_tpl  in  PIX_W  template pixel, same timing.
- oX_sram  out  COORD_W  frame address X = Xs + x.
- oY_sram  out  COORD_W  frame address Y = Ys + y.
- oX_tpl  out  COORD_W  template address X = x.
- oY_tpl  out  COORD_W  template address Y = y.
- oRd_en  out  1  addresses valid this cycle.
- oBusy  out  1  high in RUN/DRAIN.
- oDone  out  1  one-cycle completion pulse.
- oScore  out  ACC_W  final score; held until the next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and accumulator 0. Async assert; reset mid-run abandons the run with no oDone.
- FSM:
  - IDLE: on iStart, latch origin, clear x/y/accumulator and the valid pipe, go RUN.
  - RUN: oRd_en=1, one address per cycle in raster order (x fastest). At x=TPL_W-1, x:=0 and y:=y+1. At (TPL_W-1, TPL_H-1), go DRAIN.
  - DRAIN: RD_LAT cycles, oRd_en=0. Go DONE when the last valid sample has been accumulated; if RD_LAT=0, go straight to DONE.
  - DONE: oScore<=acc, oDone=1 for one cycle, go IDLE.
- Valid alignment: an RD_LAT-deep shift register carries oRd_en; accumulate only when its tap is 1.
- Per-sample score: MAXPIX - |a-b|, computed unsigned without wrap; a==b gives MAXPIX.
- Latency: accepted iStart at cycle 0 gives oDone at cycle TPL_W*TPL_H + RD_LAT + 1.
- Address sum wraps modulo 2^COORD_W; no range check.
- iStart while busy or in DONE is ignored (not queued). iStart in the same cycle as oDone is ignored.
- oX_sram/oY_sram/oX_tpl/oY_tpl hold their last value when oRd_en=0.

Optional Feature:
- CORR_BEST_TRACK_EN.
- Defined: adds input iClr_best and outputs oBest_score (ACC_W), oBest_X, oBest_Y (COORD_W).
  - On each oDone, if score > oBest_score, update oBest_score and store the latched origin. Ties keep the earlier position.
  - iClr_best clears all three to 0; it wins over a simultaneous update.
  - Reset clears all three.
- Undefined: these ports and registers are absent; core behaviour is identical.

Decomposition:
- Package corr_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE) and an abs-diff score function.
- One sub-module: corr_valid_pipe, a parametrised RD_LAT delay line for the valid bit.

Test Plan (TPL_W=4, TPL_H=2, PIX_W=10, RD_LAT=2 unless noted):
- Identical pixels, start at (100,50) -> oScore=8184 (8 x 1023); oDone at cycle 11; oX_sram sequence 100..103 twice, oY_sram 50 then 51.
- sram=1023, tpl=0 throughout -> oScore=0; sram=0, tpl=1023 -> oScore=0 (symmetry check).
- iStart pulsed during RUN -> ignored; exactly one oDone; oScore unchanged by the extra pulse.
- iRST_N low at cycle 5 -> all outputs 0 immediately, no oDone; a new start afterwards gives the correct score.
- RD_LAT=0 and RD_LAT=4 with identical data -> oScore=8184 in both; oDone at cycles 9 and 13.
- CORR_BEST_TRACK_EN: runs scoring 5000 at (10,10), 7000 at (20,5), 7000 at (30,0) -> best=7000 at (20,5); iClr_best -> all 0.
